// File: rtl/tug_pkg.sv
// Shared types for the tug-of-war match controller: sequencer states and winner codes.
package tug_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    PLAY,
    LATCH,
    SETTLE,
    HOLD,
    OVER
  } seq_state_t;

  typedef logic [1:0] winner_t;

  localparam winner_t WIN_NONE  = 2'b00;
  localparam winner_t WIN_LEFT  = 2'b01;
  localparam winner_t WIN_RIGHT = 2'b10;

  // Only a single-hot code names a real winner; 00 and 11 are treated as noise.
  function automatic logic winner_valid(input winner_t w);
    return (w == WIN_LEFT) || (w == WIN_RIGHT);
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter that paces the between-round result display.
module hold_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/round_sequencer.sv
// Match-level controller: runs each round (clear, play, score, hold) and ends the match.
module round_sequencer
  import tug_pkg::*;
#(
  parameter logic [2:0] WIN_SCORE   = 3'd7,
  parameter int         HOLD_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       done,
  input  logic [1:0] winner,
  input  logic [2:0] score_left,
  input  logic [2:0] score_right,
  output logic       game_en,
  output logic       round_clear,
  output logic       match_over,
  output logic [1:0] champion,
  output logic [3:0] round_cnt
);

  // A one-cycle hold would need a zero-width counter; keep at least one bit.
  localparam int          TW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);

  seq_state_t state, state_nxt;
  winner_t    champion_nxt;
  logic       start_q, done_q;
  logic       start_rise, done_rise;
  logic       timer_zero;

  assign start_rise = start & ~start_q;
  assign done_rise  = done & ~done_q;

  hold_timer #(.W(TW)) u_hold_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (state == SETTLE),
    .load_val (HOLD_LOAD),
    .en       (state == HOLD),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      champion  <= WIN_NONE;
      round_cnt <= '0;
    end else begin
      state    <= state_nxt;
      start_q  <= start;
      done_q   <= done;
      champion <= champion_nxt;
      if ((state == LATCH) && (round_cnt != 4'd15)) begin
        round_cnt <= round_cnt + 4'd1;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    champion_nxt = champion;
    unique case (state)
      IDLE:   if (start_rise) state_nxt = CLEAR;
      CLEAR:  state_nxt = PLAY;
      PLAY:   if (done_rise && winner_valid(winner)) state_nxt = LATCH;
      LATCH:  state_nxt = SETTLE;
      SETTLE: begin
        if (score_left == WIN_SCORE) begin
          state_nxt    = OVER;
          champion_nxt = WIN_LEFT;
        end else if (score_right == WIN_SCORE) begin
          state_nxt    = OVER;
          champion_nxt = WIN_RIGHT;
        end else begin
          state_nxt = HOLD;
        end
      end
      HOLD:   if (timer_zero) state_nxt = CLEAR;
      OVER:   state_nxt = OVER;
      default: state_nxt = IDLE;
    endcase
  end

  assign game_en     = (state == PLAY);
  assign round_clear = (state == CLEAR);
  assign match_over  = (state == OVER);

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer with HOLD_CYCLES=4 and a behavioural scoreboard.
module tb_round_sequencer;
  import tug_pkg::*;

  logic       clk = 1'b0;
  logic       reset, start, done;
  logic [1:0] winner;
  logic [2:0] score_left, score_right;
  logic       game_en, round_clear, match_over;
  logic [1:0] champion;
  logic [3:0] round_cnt;

  logic       sb_auto, sb_done_q, sb_pend;
  logic [1:0] sb_win;
  int         n_tests = 0;
  int         n_fail  = 0;

  round_sequencer #(.WIN_SCORE(3'd7), .HOLD_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .done        (done),
    .winner      (winner),
    .score_left  (score_left),
    .score_right (score_right),
    .game_en     (game_en),
    .round_clear (round_clear),
    .match_over  (match_over),
    .champion    (champion),
    .round_cnt   (round_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard: commits one cycle after the done rise it sees while play is enabled.
  always @(posedge clk) begin
    if (reset) begin
      sb_done_q   <= 1'b0;
      sb_pend     <= 1'b0;
      sb_win      <= 2'b00;
      score_left  <= 3'd0;
      score_right <= 3'd0;
    end else begin
      sb_done_q <= done;
      sb_pend   <= sb_auto && done && !sb_done_q && game_en;
      sb_win    <= winner;
      if (sb_pend && sb_win == 2'b01 && score_left != 3'd7)  score_left  <= score_left + 3'd1;
      if (sb_pend && sb_win == 2'b10 && score_right != 3'd7) score_right <= score_right + 3'd1;
    end
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".game_en"},     8'(game_en),     8'd0);
    check({tag, ".round_clear"}, 8'(round_clear), 8'd0);
    check({tag, ".match_over"},  8'(match_over),  8'd0);
    check({tag, ".champion"},    8'(champion),    8'd0);
    check({tag, ".round_cnt"},   8'(round_cnt),   8'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic press_start();
    start = 1'b1;
    tick();           // CLEAR
    start = 1'b0;
    tick();           // PLAY
  endtask

  // From PLAY: raise done in cycle m, return at m+3 (HOLD or OVER).
  task automatic do_win(input logic [1:0] w, input bit keep_done);
    winner = w;
    done   = 1'b1;
    tick();           // m+1 LATCH
    if (!keep_done) done = 1'b0;
    tick();           // m+2 SETTLE
    tick();           // m+3
  endtask

  // From m+3 in HOLD: four HOLD cycles, then CLEAR, then PLAY.
  task automatic finish_hold();
    repeat (4) tick();
    tick();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; done = 1'b0; winner = WIN_NONE; sb_auto = 1'b1;
    do_reset();
    check_idle_outputs("reset");

    // Start: round_clear for exactly one cycle, then play.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start.n1.round_clear", 8'(round_clear), 8'd1);
    check("start.n1.game_en",     8'(game_en),     8'd0);
    tick();
    check("start.n2.round_clear", 8'(round_clear), 8'd0);
    check("start.n2.game_en",     8'(game_en),     8'd1);
    tick();
    check("start.n3.game_en",     8'(game_en),     8'd1);

    // First right win with full hold sequence.
    winner = WIN_RIGHT;
    done   = 1'b1;
    tick();
    done = 1'b0;
    check("r1.m1.game_en",   8'(game_en),   8'd0);
    check("r1.m1.round_cnt", 8'(round_cnt), 8'd0);
    tick();
    check("r1.m2.round_cnt",   8'(round_cnt),   8'd1);
    check("r1.m2.score_right", 8'(score_right), 8'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("r1.hold%0d.clear", i), 8'(round_clear), 8'd0);
      check($sformatf("r1.hold%0d.en", i),    8'(game_en),     8'd0);
      tick();
    end
    check("r1.clear",       8'(round_clear), 8'd1);
    check("r1.clear.champ", 8'(champion),    8'd0);
    tick();
    check("r1.play", 8'(game_en), 8'd1);

    // Invalid winner code is ignored.
    winner = WIN_NONE;
    done   = 1'b1;
    tick();
    tick();
    check("w00.game_en",   8'(game_en),   8'd1);
    check("w00.round_cnt", 8'(round_cnt), 8'd1);
    done = 1'b0;
    tick();

    // done held high through hold/CLEAR into PLAY does not score again.
    do_win(WIN_RIGHT, 1'b1);
    finish_hold();
    tick();
    tick();
    check("held.game_en",     8'(game_en),     8'd1);
    check("held.round_cnt",   8'(round_cnt),   8'd2);
    check("held.score_right", 8'(score_right), 8'd2);
    done = 1'b0;
    tick();

    // Right wins 3..6, then the seventh ends the match.
    for (int r = 3; r <= 6; r++) begin
      do_win(WIN_RIGHT, 1'b0);
      finish_hold();
    end
    check("r6.play",      8'(game_en),    8'd1);
    check("r6.match_over", 8'(match_over), 8'd0);
    do_win(WIN_RIGHT, 1'b0);
    check("over.match_over", 8'(match_over), 8'd1);
    check("over.champion",   8'(champion),   8'd2);
    check("over.round_cnt",  8'(round_cnt),  8'd7);
    check("over.game_en",    8'(game_en),    8'd0);
    start = 1'b1; tick(); start = 1'b0; tick();
    winner = WIN_LEFT; done = 1'b1; tick(); done = 1'b0; tick(); tick();
    check("over.hold.match_over",  8'(match_over),  8'd1);
    check("over.hold.champion",    8'(champion),    8'd2);
    check("over.hold.round_clear", 8'(round_clear), 8'd0);
    check("over.hold.game_en",     8'(game_en),     8'd0);
    check("over.hold.round_cnt",   8'(round_cnt),   8'd7);

    // Reset during HOLD, then during PLAY.
    do_reset();
    check_idle_outputs("rst_over");
    press_start();
    do_win(WIN_LEFT, 1'b0);
    check("rst_hold.pre.round_cnt", 8'(round_cnt), 8'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_outputs("rst_hold");
    tick();
    tick();
    check_idle_outputs("rst_hold.idle");
    press_start();
    check("rst_play.pre.game_en", 8'(game_en), 8'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_outputs("rst_play");

    // Left side reaches the win score.
    press_start();
    for (int r = 1; r <= 6; r++) begin
      do_win(WIN_LEFT, 1'b0);
      finish_hold();
    end
    check("left6.champion", 8'(champion), 8'd0);
    do_win(WIN_LEFT, 1'b0);
    check("left.match_over", 8'(match_over), 8'd1);
    check("left.champion",   8'(champion),   8'd1);

    // Round counter saturation with the scoreboard frozen at zero.
    sb_auto = 1'b0;
    do_reset();
    press_start();
    for (int r = 1; r <= 17; r++) begin
      winner = WIN_LEFT;
      done   = 1'b1;
      tick();
      done = 1'b0;
      tick();
      check($sformatf("sat.r%0d.round_cnt", r), 8'(round_cnt), (r > 15) ? 8'd15 : 8'(r));
      tick();
      finish_hold();
    end
    check("sat.match_over", 8'(match_over), 8'd0);
    check("sat.game_en",    8'(game_en),    8'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
